// File: rtl/branch_ctrl_seq_if.sv
// rtl/branch_ctrl_seq_if.sv - datapath/sequencer signal bundle; Illegal exists only with ILLEGAL_TRAP_EN
interface branch_ctrl_seq_if;
    logic        Run;
    logic [31:0] IR;
    logic        BranchMet;
    logic        Mem_ready;
    logic        PCout, Zlowout, MDRout, Cout, Rout;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin, CONIn;
    logic        IncPC, Read, ADD, Gra;
    logic        Halted;
`ifdef ILLEGAL_TRAP_EN
    logic        Illegal;
`endif

    modport master (
        output Run, IR, BranchMet, Mem_ready,
        input  PCout, Zlowout, MDRout, Cout, Rout,
        input  MARin, Zin, PCin, MDRin, IRin, Yin, CONIn,
        input  IncPC, Read, ADD, Gra, Halted
`ifdef ILLEGAL_TRAP_EN
        , input Illegal
`endif
    );

    modport slave (
        input  Run, IR, BranchMet, Mem_ready,
        output PCout, Zlowout, MDRout, Cout, Rout,
        output MARin, Zin, PCin, MDRin, IRin, Yin, CONIn,
        output IncPC, Read, ADD, Gra, Halted
`ifdef ILLEGAL_TRAP_EN
        , output Illegal
`endif
    );
endinterface

// File: rtl/branch_ctrl_seq.sv
// rtl/branch_ctrl_seq.sv - fetch + conditional-branch control sequencer; ILLEGAL_TRAP_EN traps unknown opcodes to HALT
module branch_ctrl_seq (
    input logic             Clock,
    input logic             Clear,
    branch_ctrl_seq_if.slave bus
);
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    state_t     state, next;
    logic [4:0] opcode;
    logic       unused_ir;

    assign opcode    = bus.IR[31:27];
    assign unused_ir = ^bus.IR[26:0];

    always_ff @(posedge Clock) begin
        if (Clear) state <= S_IDLE;
        else       state <= next;
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge Clock) begin
        if (Clear)
            illegal_q <= 1'b0;
        else if (state == S_T3 && opcode != OP_BR && opcode != OP_HALT && opcode != OP_NOP)
            illegal_q <= 1'b1;
    end

    assign bus.Illegal = illegal_q;
`endif

    always_comb begin
        next        = state;
        bus.PCout   = 1'b0; bus.Zlowout = 1'b0; bus.MDRout = 1'b0;
        bus.Cout    = 1'b0; bus.Rout    = 1'b0;
        bus.MARin   = 1'b0; bus.Zin     = 1'b0; bus.PCin   = 1'b0;
        bus.MDRin   = 1'b0; bus.IRin    = 1'b0; bus.Yin    = 1'b0;
        bus.CONIn   = 1'b0;
        bus.IncPC   = 1'b0; bus.Read    = 1'b0; bus.ADD    = 1'b0;
        bus.Gra     = 1'b0; bus.Halted  = 1'b0;
        case (state)
            S_IDLE: if (bus.Run) next = S_T0;
            S_T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
                next = S_T1;
            end
            // Z is not reloaded here, so holding T1 while memory stalls keeps PC stable
            S_T1: begin
                bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
                if (bus.Mem_ready) next = S_T2;
            end
            S_T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
                next = S_T3;
            end
            S_T3: begin
                if (opcode == OP_BR) begin
                    bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONIn = 1'b1;
                    next = S_T4;
                end else if (opcode == OP_HALT) begin
                    next = S_HALT;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    if (opcode == OP_NOP) next = bus.Run ? S_T0 : S_IDLE;
                    else                  next = S_HALT;
`else
                    next = bus.Run ? S_T0 : S_IDLE;
`endif
                end
            end
            S_T4: begin
                bus.PCout = 1'b1; bus.Yin = 1'b1;
                next = S_T5;
            end
            S_T5: begin
                bus.Cout = 1'b1; bus.ADD = 1'b1; bus.Zin = 1'b1;
                next = S_T6;
            end
            // PC load follows the CON flip-flop directly: taken branches commit Z, others leave PC as is
            S_T6: begin
                bus.Zlowout = 1'b1; bus.PCin = bus.BranchMet;
                next = bus.Run ? S_T0 : S_IDLE;
            end
            S_HALT:  bus.Halted = 1'b1;
            default: next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_branch_ctrl_seq.sv
// tb/tb_branch_ctrl_seq.sv - vector-table bench for branch_ctrl_seq; honours ILLEGAL_TRAP_EN
module tb_branch_ctrl_seq;
    logic Clock = 1'b0;
    logic Clear = 1'b0;
    branch_ctrl_seq_if bus ();

    branch_ctrl_seq dut (.Clock(Clock), .Clear(Clear), .bus(bus));

    always #5 Clock = ~Clock;

    // strobe vector order: PCout Zlowout MDRout Cout Rout MARin Zin PCin MDRin IRin Yin CONIn IncPC Read ADD Gra Halted
    localparam logic [16:0] B_PCOUT  = 17'(1) << 16, B_ZLOW  = 17'(1) << 15, B_MDROUT = 17'(1) << 14;
    localparam logic [16:0] B_COUT   = 17'(1) << 13, B_ROUT  = 17'(1) << 12, B_MARIN  = 17'(1) << 11;
    localparam logic [16:0] B_ZIN    = 17'(1) << 10, B_PCIN  = 17'(1) << 9,  B_MDRIN  = 17'(1) << 8;
    localparam logic [16:0] B_IRIN   = 17'(1) << 7,  B_YIN   = 17'(1) << 6,  B_CONIN  = 17'(1) << 5;
    localparam logic [16:0] B_INCPC  = 17'(1) << 4,  B_READ  = 17'(1) << 3,  B_ADD    = 17'(1) << 2;
    localparam logic [16:0] B_GRA    = 17'(1) << 1,  B_HALTED = 17'(1);

    localparam logic [16:0] E_IDLE = 17'd0;
    localparam logic [16:0] E_T0   = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [16:0] E_T1   = B_ZLOW | B_PCIN | B_READ | B_MDRIN;
    localparam logic [16:0] E_T2   = B_MDROUT | B_IRIN;
    localparam logic [16:0] E_T3BR = B_GRA | B_ROUT | B_CONIN;
    localparam logic [16:0] E_T4   = B_PCOUT | B_YIN;
    localparam logic [16:0] E_T5   = B_COUT | B_ADD | B_ZIN;
    localparam logic [16:0] E_T6Y  = B_ZLOW | B_PCIN;
    localparam logic [16:0] E_T6N  = B_ZLOW;
    localparam logic [16:0] E_HALT = B_HALTED;

    localparam logic [31:0] IR_BR   = 32'h9118_0023;
    localparam logic [31:0] IR_NOP  = 32'hD000_0000;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;
    localparam logic [31:0] IR_BAD  = 32'hF800_0000;

    typedef struct {
        logic        run;
        logic        mr;
        logic [31:0] ir;
        logic        bm;
        logic [16:0] exp;
    } vec_t;

    vec_t        vecs[$];
    int          checks = 0;
    int          failures = 0;
    logic [16:0] got;

    assign got = {bus.PCout, bus.Zlowout, bus.MDRout, bus.Cout, bus.Rout,
                  bus.MARin, bus.Zin, bus.PCin, bus.MDRin, bus.IRin, bus.Yin, bus.CONIn,
                  bus.IncPC, bus.Read, bus.ADD, bus.Gra, bus.Halted};

    task automatic add(input logic run, input logic mr, input logic [31:0] ir,
                       input logic bm, input logic [16:0] exp);
        vec_t v;
        v.run = run; v.mr = mr; v.ir = ir; v.bm = bm; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%05h required=%05h", name, act, exp);
        end
    endtask

    task automatic drive(input logic clr, input logic run, input logic mr,
                         input logic [31:0] ir, input logic bm);
        @(negedge Clock);
        Clear = clr; bus.Run = run; bus.Mem_ready = mr; bus.IR = ir; bus.BranchMet = bm;
        #1;
    endtask

    initial begin
        bus.Run = 1'b0; bus.Mem_ready = 1'b0; bus.IR = 32'd0; bus.BranchMet = 1'b0;

        // idle hold, then taken branch with no stalls
        for (int i = 0; i < 5; i++) add(0, 0, IR_BR, 0, E_IDLE);
        add(1, 1, IR_BR, 1, E_IDLE);
        add(1, 1, IR_BR, 1, E_T0);
        add(1, 1, IR_BR, 1, E_T1);
        add(1, 1, IR_BR, 1, E_T2);
        add(1, 1, IR_BR, 1, E_T3BR);
        add(1, 1, IR_BR, 1, E_T4);
        add(1, 1, IR_BR, 1, E_T5);
        add(1, 1, IR_BR, 1, E_T6Y);
        // not-taken branch; Run dropped mid-instruction still completes it
        add(1, 1, IR_BR, 0, E_T0);
        add(1, 1, IR_BR, 0, E_T1);
        add(0, 1, IR_BR, 0, E_T2);
        add(0, 1, IR_BR, 0, E_T3BR);
        add(0, 1, IR_BR, 0, E_T4);
        add(0, 1, IR_BR, 0, E_T5);
        add(0, 1, IR_BR, 0, E_T6N);
        add(0, 1, IR_BR, 0, E_IDLE);
        // three memory stall cycles, then NOP, then HALT
        add(1, 0, IR_NOP, 0, E_IDLE);
        add(1, 0, IR_NOP, 0, E_T0);
        add(1, 0, IR_NOP, 0, E_T1);
        add(1, 0, IR_NOP, 0, E_T1);
        add(1, 0, IR_NOP, 0, E_T1);
        add(1, 1, IR_NOP, 0, E_T1);
        add(1, 0, IR_NOP, 0, E_T2);
        add(1, 0, IR_NOP, 0, E_IDLE);
        add(1, 1, IR_HALT, 0, E_T0);
        add(1, 1, IR_HALT, 0, E_T1);
        add(1, 1, IR_HALT, 0, E_T2);
        add(1, 1, IR_HALT, 0, E_IDLE);
        add(1, 1, IR_HALT, 1, E_HALT);
        add(1, 1, IR_BR, 1, E_HALT);
        add(1, 1, IR_BR, 1, E_HALT);

        drive(1, 0, 0, 32'd0, 0);
        drive(0, 0, 0, 32'd0, 0);
        check("reset_idle", got, E_IDLE);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(0, vecs[i].run, vecs[i].mr, vecs[i].ir, vecs[i].bm);
            check($sformatf("vec%0d", i), got, vecs[i].exp);
        end

        // Clear leaves HALT
        drive(1, 0, 0, IR_BR, 0);
        drive(0, 0, 0, IR_BR, 0);
        check("halt_clear", got, E_IDLE);

        // Clear during T5 aborts the branch
        drive(0, 1, 1, IR_BR, 1); check("c5_idle", got, E_IDLE);
        drive(0, 1, 1, IR_BR, 1); check("c5_t0", got, E_T0);
        drive(0, 1, 1, IR_BR, 1); check("c5_t1", got, E_T1);
        drive(0, 1, 1, IR_BR, 1); check("c5_t2", got, E_T2);
        drive(0, 1, 1, IR_BR, 1); check("c5_t3", got, E_T3BR);
        drive(0, 1, 1, IR_BR, 1); check("c5_t4", got, E_T4);
        drive(0, 1, 1, IR_BR, 1); check("c5_t5", got, E_T5);
        Clear = 1'b1;
        drive(0, 0, 1, IR_BR, 1); check("c5_abort", got, E_IDLE);

        // Clear wins over Mem_ready in T1
        drive(0, 1, 0, IR_BR, 0); check("cm_idle", got, E_IDLE);
        drive(0, 1, 0, IR_BR, 0); check("cm_t0", got, E_T0);
        drive(1, 1, 1, IR_BR, 0); check("cm_t1", got, E_T1);
        drive(0, 0, 1, IR_BR, 0); check("cm_abort", got, E_IDLE);

        // unrecognised opcode
        drive(0, 1, 1, IR_BAD, 0); check("bad_idle", got, E_IDLE);
        drive(0, 1, 1, IR_BAD, 0); check("bad_t0", got, E_T0);
        drive(0, 1, 1, IR_BAD, 0); check("bad_t1", got, E_T1);
        drive(0, 1, 1, IR_BAD, 0); check("bad_t2", got, E_T2);
        drive(0, 1, 1, IR_BAD, 0); check("bad_t3", got, E_IDLE);
`ifdef ILLEGAL_TRAP_EN
        check("bad_illegal_t3", {16'd0, bus.Illegal}, 17'd0);
        drive(0, 1, 1, IR_BAD, 0); check("bad_halt", got, E_HALT);
        check("bad_illegal", {16'd0, bus.Illegal}, 17'd1);
        drive(1, 0, 0, IR_BAD, 0);
        drive(0, 0, 0, IR_BAD, 0); check("bad_clear", got, E_IDLE);
        check("bad_illegal_clr", {16'd0, bus.Illegal}, 17'd0);
`else
        drive(0, 1, 1, IR_BAD, 0); check("bad_as_nop", got, E_T0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
